// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback sequencer.
// The WB_STACK_OPS_EN macro (see wb_decode) enables the push/pop instruction classes.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WB1     = 2'd1,
    ST_WB2     = 2'd2,
    ST_DONE_NW = 2'd3
  } wb_state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_JR      = 3'd1,
    CLS_LW      = 3'd2,
    CLS_IALU    = 3'd3,
    CLS_JAL     = 3'd4,
    CLS_PUSH    = 3'd5,
    CLS_POP     = 3'd6,
    CLS_ILLEGAL = 3'd7
  } wb_class_e;

  localparam logic [5:0] OPC_RTYPE   = 6'h00;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_SLTI    = 6'h0A;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_PUSH    = 6'h38;
  localparam logic [5:0] OPC_POP     = 6'h39;
  localparam logic [5:0] FN_JR       = 6'h08;

  localparam logic [2:0] DST_RT      = 3'b000;
  localparam logic [2:0] DST_RD      = 3'b001;
  localparam logic [2:0] DST_RS      = 3'b010;
  localparam logic [2:0] DST_SP      = 3'b011;
  localparam logic [2:0] DST_RA      = 3'b100;

  localparam logic [1:0] SRC_ALU     = 2'b00;
  localparam logic [1:0] SRC_MDR     = 2'b01;
  localparam logic [1:0] SRC_PC      = 2'b10;

  // Destination/source of the first (or only) write of a class.
  function automatic logic [2:0] cls_dst(input wb_class_e cls);
    case (cls)
      CLS_RTYPE: cls_dst = DST_RD;
      CLS_JAL:   cls_dst = DST_RA;
      CLS_PUSH:  cls_dst = DST_SP;
      default:   cls_dst = DST_RT;
    endcase
  endfunction

  function automatic logic [1:0] cls_src(input wb_class_e cls);
    case (cls)
      CLS_LW,
      CLS_POP:   cls_src = SRC_MDR;
      CLS_JAL:   cls_src = SRC_PC;
      default:   cls_src = SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/wb_decode.sv
// Combinational opcode/funct -> instruction-class decoder.
// Macro WB_STACK_OPS_EN: when undefined, the push/pop opcodes decode as illegal.
module wb_decode
  import wb_pkg::*;
#(
  parameter logic [5:0] OP_PUSH = OPC_PUSH,
  parameter logic [5:0] OP_POP  = OPC_POP
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output wb_class_e  cls
);

  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OPC_RTYPE: cls = (funct == FN_JR) ? CLS_JR : CLS_RTYPE;
      OPC_LW:    cls = CLS_LW;
      OPC_ADDI,
      OPC_SLTI,
      OPC_ANDI,
      OPC_ORI,
      OPC_LUI:   cls = CLS_IALU;
      OPC_JAL:   cls = CLS_JAL;
      default: begin
`ifdef WB_STACK_OPS_EN
        if (opcode == OP_PUSH)
          cls = CLS_PUSH;
        else if (opcode == OP_POP)
          cls = CLS_POP;
`endif
      end
    endcase
  end

endmodule

// File: rtl/wb_sequencer.sv
// Multicycle writeback sequencer: drives register-file write controls for one instruction.
// Macro WB_STACK_OPS_EN enables the push/pop sequences (WB2 state, $29 destination).
module wb_sequencer
  import wb_pkg::*;
#(
  parameter logic [5:0] OP_PUSH = OPC_PUSH,
  parameter logic [5:0] OP_POP  = OPC_POP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wb_start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       wb_busy,
  output logic       wb_done,
  output logic [2:0] regDSTmux,
  output logic [1:0] wbSrcSel,
  output logic       regWrite,
  output logic       illegal
);

  wb_state_e  state_q;
  logic [5:0] opcode_q;
  logic [5:0] funct_q;
  logic       busy_q;
  logic       done_q;
  logic [2:0] dst_q;
  logic [1:0] src_q;
  logic       wr_q;
  logic       ill_q;

  logic [5:0] dec_opcode_d;
  logic [5:0] dec_funct_d;
  wb_class_e  cls_d;

  // One decoder serves both the incoming instruction (in IDLE) and the latched one.
  assign dec_opcode_d = (state_q == ST_IDLE) ? opcode : opcode_q;
  assign dec_funct_d  = (state_q == ST_IDLE) ? funct  : funct_q;

  wb_decode #(
    .OP_PUSH (OP_PUSH),
    .OP_POP  (OP_POP)
  ) u_decode (
    .opcode (dec_opcode_d),
    .funct  (dec_funct_d),
    .cls    (cls_d)
  );

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      funct_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dst_q    <= DST_RT;
      src_q    <= SRC_ALU;
      wr_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      // Default: return to the quiet IDLE output pattern.
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dst_q   <= DST_RT;
      src_q   <= SRC_ALU;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wb_start) begin
            opcode_q <= opcode;
            funct_q  <= funct;
            busy_q   <= 1'b1;
            if (cls_d == CLS_JR || cls_d == CLS_ILLEGAL) begin
              state_q <= ST_DONE_NW;
              done_q  <= 1'b1;
              ill_q   <= (cls_d == CLS_ILLEGAL);
            end else begin
              state_q <= ST_WB1;
              wr_q    <= 1'b1;
              dst_q   <= cls_dst(cls_d);
              src_q   <= cls_src(cls_d);
              done_q  <= (cls_d != CLS_POP);
            end
          end
        end
        ST_WB1: begin
`ifdef WB_STACK_OPS_EN
          if (cls_d == CLS_POP) begin
            state_q <= ST_WB2;
            busy_q  <= 1'b1;
            wr_q    <= 1'b1;
            dst_q   <= DST_SP;
            src_q   <= SRC_ALU;
            done_q  <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign wb_busy   = busy_q;
  assign wb_done   = done_q;
  assign regDSTmux = dst_q;
  assign wbSrcSel  = src_q;
  assign regWrite  = wr_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed, table-driven bench for wb_sequencer; honours WB_STACK_OPS_EN when defined.
module tb_wb_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wb_start;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       wb_busy;
  logic       wb_done;
  logic [2:0] regDSTmux;
  logic [1:0] wbSrcSel;
  logic       regWrite;
  logic       illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .wb_start  (wb_start),
    .opcode    (opcode),
    .funct     (funct),
    .wb_busy   (wb_busy),
    .wb_done   (wb_done),
    .regDSTmux (regDSTmux),
    .wbSrcSel  (wbSrcSel),
    .regWrite  (regWrite),
    .illegal   (illegal)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic [5:0] opc;
    logic [5:0] fn;
    logic       busy;
    logic       done;
    logic [2:0] dst;
    logic [1:0] src;
    logic       wr;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then sample the registered outputs.
  task automatic step(input logic rst, input logic start, input logic [5:0] opc, input logic [5:0] fn);
    reset    = rst;
    wb_start = start;
    opcode   = opc;
    funct    = fn;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, ".busy"}, {7'd0, wb_busy},   {7'd0, v.busy});
    check({tag, ".done"}, {7'd0, wb_done},   {7'd0, v.done});
    check({tag, ".dst"},  {5'd0, regDSTmux}, {5'd0, v.dst});
    check({tag, ".src"},  {6'd0, wbSrcSel},  {6'd0, v.src});
    check({tag, ".wr"},   {7'd0, regWrite},  {7'd0, v.wr});
    check({tag, ".ill"},  {7'd0, illegal},   {7'd0, v.ill});
  endtask

  initial begin
    reset = 1'b1; wb_start = 1'b0; opcode = '0; funct = '0;
    @(negedge clk);

    //            rst   st    opc    fn     busy  done  dst     src    wr    ill
    vecs.push_back('{1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0}); // reset
    vecs.push_back('{1'b0, 1'b1, 6'h00, 6'h20, 1'b1, 1'b1, 3'b001, 2'b00, 1'b1, 1'b0}); // add
    vecs.push_back('{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'h23, 6'h00, 1'b1, 1'b1, 3'b000, 2'b01, 1'b1, 1'b0}); // lw
    vecs.push_back('{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'h03, 6'h00, 1'b1, 1'b1, 3'b100, 2'b10, 1'b1, 1'b0}); // jal
    vecs.push_back('{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'h00, 6'h08, 1'b1, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0}); // jr
    vecs.push_back('{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'h3F, 6'h00, 1'b1, 1'b1, 3'b000, 2'b00, 1'b0, 1'b1}); // illegal
    vecs.push_back('{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'h0D, 6'h3F, 1'b1, 1'b1, 3'b000, 2'b00, 1'b1, 1'b0}); // ori
    vecs.push_back('{1'b0, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0}); // start during wb_done: ignored
    vecs.push_back('{1'b0, 1'b1, 6'h00, 6'h22, 1'b1, 1'b1, 3'b001, 2'b00, 1'b1, 1'b0}); // sub
    vecs.push_back('{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0});
`ifdef WB_STACK_OPS_EN
    vecs.push_back('{1'b0, 1'b1, 6'h38, 6'h00, 1'b1, 1'b1, 3'b011, 2'b00, 1'b1, 1'b0}); // push
    vecs.push_back('{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'h39, 6'h00, 1'b1, 1'b0, 3'b000, 2'b01, 1'b1, 1'b0}); // pop WB1
    vecs.push_back('{1'b0, 1'b1, 6'h00, 6'h20, 1'b1, 1'b1, 3'b011, 2'b00, 1'b1, 1'b0}); // pop WB2, start ignored
`else
    vecs.push_back('{1'b0, 1'b1, 6'h38, 6'h00, 1'b1, 1'b1, 3'b000, 2'b00, 1'b0, 1'b1}); // push illegal
    vecs.push_back('{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'h39, 6'h00, 1'b1, 1'b1, 3'b000, 2'b00, 1'b0, 1'b1}); // pop illegal
    vecs.push_back('{1'b0, 1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0}); // start in DONE_NW ignored
`endif
    vecs.push_back('{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0}); // reset beats start
    vecs.push_back('{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'h0F, 6'h00, 1'b1, 1'b1, 3'b000, 2'b00, 1'b1, 1'b0}); // lui
    vecs.push_back('{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].opc, vecs[i].fn);
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset in WB1 of a pop: the sequence is dropped with no WB2 write and no wb_done.
    begin
      vec_t quiet;
      int   extra_wr;
      quiet = '{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0};
      step(1'b0, 1'b1, 6'h39, 6'h00);
`ifdef WB_STACK_OPS_EN
      check("pop_abort.wb1_wr",   {7'd0, regWrite}, 8'd1);
      check("pop_abort.wb1_done", {7'd0, wb_done},  8'd0);
`else
      check("pop_abort.ill",      {7'd0, illegal},  8'd1);
`endif
      step(1'b1, 1'b0, 6'h00, 6'h00);
      check_vec("pop_abort.rst", quiet);
      extra_wr = 0;
      for (int c = 0; c < 3; c++) begin
        step(1'b0, 1'b0, 6'h00, 6'h00);
        if (regWrite || wb_done || wb_busy) extra_wr++;
      end
      check("pop_abort.no_wb2", extra_wr[7:0], 8'd0);
    end

    // Back-to-back: jal then a start one cycle after wb_done is accepted normally.
    step(1'b0, 1'b1, 6'h03, 6'h00);
    check("b2b.jal_dst", {5'd0, regDSTmux}, 8'd4);
    step(1'b0, 1'b0, 6'h00, 6'h00);
    step(1'b0, 1'b1, 6'h0A, 6'h00);
    check("b2b.slti_wr",   {7'd0, regWrite}, 8'd1);
    check("b2b.slti_done", {7'd0, wb_done},  8'd1);
    step(1'b0, 1'b0, 6'h00, 6'h00);
    check("b2b.idle_busy", {7'd0, wb_busy},  8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
- REQ-001: Parameter OP_PUSH, default 6'h38, opcode of the stack-push instruction.
- REQ-002: Parameter OP_POP, default 6'h39, opcode of the stack-pop instruction.
- REQ-003: clk  input  1  the single clock; all state changes on its rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: wb_start  input  1  one-cycle request to run writeback for the instruction on opcode/funct.
- REQ-006: opcode  input  6  instruction bits 31:26, sampled when wb_start is accepted.
- REQ-007: funct  input  6  instruction bits 5:0, sampled when wb_start is accepted.
- REQ-008: wb_busy  output  1  high while a writeback sequence is in progress.
- REQ-009: wb_done  output  1  one-cycle pulse in the final cycle of a sequence.
- REQ-010: regDSTmux  output  3  destination-register select: 000 rt, 001 rd, 010 rs, 011 $29, 100 $31.
- REQ-011: wbSrcSel  output  2  write-data source: 00 ALUOut, 01 MDR, 10 PC.
- REQ-012: regWrite  output  1  register-file write enable.
- REQ-013: illegal  output  1  one-cycle pulse, coincident with wb_done, for an unsupported opcode.

Function
- REQ-014: FSM states: IDLE, WB1, WB2, DONE_NW. IDLE is the reset state.
- REQ-015: opcode and funct are latched in the cycle where wb_start=1 and the FSM is in IDLE; wb_start is ignored in every other state.
- REQ-016: Classification: opcode 0 with funct≠6'h08 is R-type (rd, ALU); opcode 0 with funct 6'h08 (jr) has no write; 6'h23 lw (rt, MDR); 6'h08/0A/0C/0D/0F I-type ALU (rt, ALU); 6'h03 jal ($31, PC); OP_PUSH ($29, ALU); OP_POP (rt, MDR, then $29, ALU); all other opcodes are illegal.
- REQ-017: Single-write classes go IDLE→WB1→IDLE. In WB1: regWrite=1, the class's regDSTmux/wbSrcSel, and wb_done=1.
- REQ-018: OP_POP goes IDLE→WB1→WB2→IDLE. In WB1: rt/MDR write with wb_done=0. In WB2: $29/ALU write with wb_done=1.
- REQ-019: jr and illegal go IDLE→DONE_NW→IDLE. In DONE_NW: regWrite=0 and wb_done=1; illegal=1 only for an illegal opcode.
- REQ-020: Latency: the first regWrite or wb_done occurs in the cycle after wb_start acceptance. No sequence lasts more than 2 cycles.
- REQ-021: wb_busy=1 in WB1, WB2 and DONE_NW, and 0 in IDLE. A new wb_start in the same cycle as wb_done is ignored.
- REQ-022: regWrite is never high outside WB1/WB2. In IDLE, regDSTmux=000 and wbSrcSel=00.
- REQ-023: All outputs are decoded from the registered state and the latched class only. There is no combinational path from wb_start, opcode or funct to any output.

Reset
- REQ-024: On a clock edge with reset=1: state←IDLE, latched opcode/funct←0, and all outputs are 0 in the following cycle.
- REQ-025: Reset in WB1 of an OP_POP sequence aborts it: WB2 never occurs and no wb_done is issued.
- REQ-026: reset has priority over wb_start in the same cycle.

Configuration
- REQ-027: Macro WB_STACK_OPS_EN. When defined, OP_PUSH and OP_POP behave per REQ-016/REQ-018. When undefined, both are classified illegal (DONE_NW, illegal pulse), and state WB2 and select code 011 are never produced.

Structure
- REQ-028: Package wb_pkg holds: the state enum, the instruction-class enum, opcode/funct constants, the regDSTmux code constants (000–100), and the wbSrcSel code constants.
- REQ-029: Sub-module wb_decode is a purely combinational opcode/funct→class decoder instantiated once inside wb_sequencer.

Verification
- REQ-030: R-type add (opcode 0, funct 6'h20), wb_start at cycle 0 → cycle 1: regWrite=1, regDSTmux=001, wbSrcSel=00, wb_done=1; cycle 2: IDLE.
- REQ-031: lw (6'h23) → cycle 1: regDSTmux=000, wbSrcSel=01, regWrite=1, wb_done=1.
- REQ-032: jal (6'h03) → cycle 1: regDSTmux=100, wbSrcSel=10, regWrite=1. jr (0/6'h08) → regWrite=0, wb_done=1.
- REQ-033: OP_POP with WB_STACK_OPS_EN defined → cycle 1: 000/01 write, wb_done=0; cycle 2: 011/00 write, wb_done=1. With the macro undefined → cycle 1: illegal=1, regWrite=0.
- REQ-034: Opcode 6'h3F → illegal=1 and wb_done=1 in cycle 1, regWrite never set. A wb_start asserted during wb_busy produces no extra sequence.
- REQ-035: Reset asserted in WB1 of OP_POP → next cycle all outputs 0, and no WB2 write occurs.
